// File: rtl/hex_disp_pkg.sv
// Shared definitions for the hex display arbiter: state encoding, idle word
// and the width helper used for requester indices.
package hex_disp_pkg;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_SHOW = 1'b1;

    localparam logic [31:0] IDLE_DATA_DEF = 32'h0000_0000;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/hex_rr_pick.sv
// Combinational round-robin picker: finds the first set req bit at or after
// start, wrapping, so the bit just below start is considered last.
module hex_rr_pick
    import hex_disp_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int OW      = clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [OW-1:0]      start,
    output logic               found,
    output logic [OW-1:0]      idx
);

    logic [NUM_REQ-1:0] rot;
    logic [OW-1:0]      off;
    logic [OW:0]        sum;

    always_comb begin
        // NOTE: every output of a combinational block gets a default first;
        // a path that skips an assignment would otherwise infer a latch.
        found = 1'b0;
        off   = '0;
        rot   = NUM_REQ'({req, req} >> start);
        // Descending scan so the lowest rotated offset wins.
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (rot[k]) begin
                found = 1'b1;
                off   = OW'(k);
            end
        end
        sum = {1'b0, start} + {1'b0, off};
        idx = (sum >= (OW+1)'(NUM_REQ)) ? OW'(sum - (OW+1)'(NUM_REQ)) : OW'(sum);
    end

endmodule

// File: rtl/hex_disp_arbiter.sv
// Time-sliced round-robin sharing of the 8-digit hex display between
// NUM_REQ sources; outputs feed the display driver directly.
module hex_disp_arbiter
    import hex_disp_pkg::*;
#(
    parameter int          NUM_REQ   = 4,
    parameter int          DWELL_CYC = 50_000_000,
    parameter int          CNT_W     = 26,
    parameter logic [31:0] IDLE_DATA = IDLE_DATA_DEF
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REQ-1:0]          req,
    input  logic [NUM_REQ*32-1:0]       data_in,
    output logic [NUM_REQ-1:0]          grant,
    output logic [clog2(NUM_REQ)-1:0]   owner,
    output logic [31:0]                 disp_data,
    output logic                        disp_en,
    output logic                        switch_pulse
);

    localparam int             OW   = clog2(NUM_REQ);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DWELL_CYC - 1);

    logic [0:0]         state;
    logic [CNT_W-1:0]   cnt;
    logic [OW-1:0]      start;
    logic               pick_found;
    logic [OW-1:0]      pick_idx;
    logic [NUM_REQ-1:0] others;
    logic               take;
    logic               release_own;
    logic [31:0]        words [NUM_REQ];

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            words[i] = data_in[32*i +: 32];
        end
    end

    // Search starts just past the owner, so the owner itself is checked last.
    assign start = (owner == OW'(NUM_REQ - 1)) ? '0 : owner + OW'(1);

    hex_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .OW      (OW)
    ) u_pick (
        .req   (req),
        .start (start),
        .found (pick_found),
        .idx   (pick_idx)
    );

    // grant is zero in IDLE, so this is every request that is not the owner.
    assign others = req & ~grant;

    always_comb begin
        take        = 1'b0;
        release_own = 1'b0;
        if (state == ST_IDLE) begin
            take = pick_found;
        end else if (!req[owner]) begin
            take        = pick_found;
            release_own = !pick_found;
        end else if (cnt == LAST) begin
            take = |others;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            grant        <= '0;
            owner        <= OW'(NUM_REQ - 1);
            disp_data    <= IDLE_DATA;
            disp_en      <= 1'b0;
            switch_pulse <= 1'b0;
        end else if (take) begin
            state        <= ST_SHOW;
            cnt          <= '0;
            grant        <= NUM_REQ'(1) << pick_idx;
            owner        <= pick_idx;
            disp_data    <= words[pick_idx];
            disp_en      <= 1'b1;
            switch_pulse <= 1'b1;
        end else if (release_own) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            grant        <= '0;
            disp_data    <= IDLE_DATA;
            disp_en      <= 1'b0;
            switch_pulse <= 1'b1;
        end else begin
            switch_pulse <= 1'b0;
            if (state == ST_SHOW) begin
                disp_data <= words[owner];
                cnt       <= (cnt == LAST) ? '0 : cnt + CNT_W'(1);
            end else begin
                disp_data <= IDLE_DATA;
                cnt       <= '0;
            end
        end
    end

endmodule
